// File: rtl/fp_add_controller.sv
// Sequencing controller around an external single-precision adder: classifies
// operands, resolves special cases locally, otherwise issues to the adder with a timeout.
module fp_add_controller #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        available,
  output logic [4:0]  exception_f,
  input  logic [31:0] sum,
  input  logic        done,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags,
  output logic        out_err,
  input  logic        out_ready
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]     QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLASS = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Flags: {signs differ, any zero/denormal, any infinity, B NaN, A NaN}
  function automatic logic [4:0] classify(input logic [31:0] x, input logic [31:0] y);
    logic x_max;
    logic y_max;
    x_max = (x[30:23] == 8'hFF);
    y_max = (y[30:23] == 8'hFF);
    classify = {x[31] ^ y[31],
                (x[30:23] == 8'h00) | (y[30:23] == 8'h00),
                (x_max & ~|x[22:0]) | (y_max & ~|y[22:0]),
                y_max & |y[22:0],
                x_max & |x[22:0]};
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   cnt_r;
  logic [4:0]      flags_s;
  logic            a_inf_s;
  logic            b_inf_s;
  logic            a_zero_s;
  logic            b_zero_s;
  logic            timeout_s;
  logic [31:0]     spec_result_s;
  logic            spec_err_s;

  assign flags_s   = classify(a, b);
  assign a_inf_s   = (a[30:23] == 8'hFF) & ~|a[22:0];
  assign b_inf_s   = (b[30:23] == 8'hFF) & ~|b[22:0];
  assign a_zero_s  = (a[30:23] == 8'h00);
  assign b_zero_s  = (b[30:23] == 8'h00);
  assign timeout_s = (cnt_r == CNT_LAST);
  assign in_ready  = (state_r == S_IDLE);

  // Special-case result resolved without the adder, in priority order
  always_comb begin
    spec_result_s = QNAN;
    spec_err_s    = 1'b0;
    if (flags_s[0] | flags_s[1]) begin
      spec_result_s = QNAN;
    end else if (a_inf_s & b_inf_s & flags_s[4]) begin
      spec_err_s = 1'b1;
    end else if (a_inf_s) begin
      spec_result_s = a;
    end else if (b_inf_s) begin
      spec_result_s = b;
    end else if (a_zero_s & b_zero_s) begin
      spec_result_s = {a[31] & b[31], 31'd0};
    end else if (a_zero_s) begin
      spec_result_s = b;
    end else if (b_zero_s) begin
      spec_result_s = a;
    end else begin
      spec_err_s = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; done in the final WAIT cycle takes precedence over timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  if (in_valid) next_state_s = S_CLASS; else next_state_s = S_IDLE;
      S_CLASS: if (flags_s == 5'd0) next_state_s = S_ISSUE; else next_state_s = S_RESP;
      S_ISSUE: next_state_s = S_WAIT;
      S_WAIT:  if (done || timeout_s) next_state_s = S_RESP; else next_state_s = S_WAIT;
      S_RESP:  if (out_ready) next_state_s = S_IDLE; else next_state_s = S_RESP;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Datapath registers: operands, adder handshake, timeout counter and response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a           <= 32'd0;
      b           <= 32'd0;
      available   <= 1'b0;
      exception_f <= 5'd0;
      cnt_r       <= '0;
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_flags   <= 5'd0;
      out_err     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a <= in_a;
            b <= in_b;
          end
        end
        S_CLASS: begin
          exception_f <= flags_s;
          out_flags   <= flags_s;
          if (flags_s != 5'd0) begin
            out_valid  <= 1'b1;
            out_result <= spec_result_s;
            out_err    <= spec_err_s;
          end else begin
            available <= 1'b1;
          end
        end
        S_ISSUE: begin
          available <= 1'b0;
          cnt_r     <= '0;
        end
        S_WAIT: begin
          cnt_r <= cnt_r + CW'(1);
          if (done) begin
            out_valid <= 1'b1;
            if (sum[30:23] == 8'hFF) begin
              out_result <= {sum[31], 8'hFF, 23'd0};
              out_err    <= 1'b1;
            end else begin
              out_result <= sum;
              out_err    <= 1'b0;
            end
          end else if (timeout_s) begin
            out_valid  <= 1'b1;
            out_result <= QNAN;
            out_err    <= 1'b1;
          end
        end
        S_RESP: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
          available <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_controller.sv
// Randomized bench for fp_add_controller with an adder stand-in and a
// field-level reference model of classification, special results and latency.
module tb_fp_add_controller;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        available;
  logic [4:0]  exception_f;
  logic [31:0] sum = 32'd0;
  logic        done = 1'b0;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        out_err;
  logic        out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .a(a), .b(b), .available(available),
    .exception_f(exception_f), .sum(sum), .done(done), .out_valid(out_valid),
    .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference classification and special-case result from magnitudes.
  function automatic void ref_model(input logic [31:0] x, input logic [31:0] y,
                                    output logic [4:0] fl, output logic exc,
                                    output logic [31:0] res, output logic err);
    logic [31:0] mx, my;
    logic nx, ny, ix, iy, zx, zy, sd;
    mx = x & 32'h7FFF_FFFF;
    my = y & 32'h7FFF_FFFF;
    nx = mx > 32'h7F80_0000;
    ny = my > 32'h7F80_0000;
    ix = mx == 32'h7F80_0000;
    iy = my == 32'h7F80_0000;
    zx = mx < 32'h0080_0000;
    zy = my < 32'h0080_0000;
    sd = (x >> 31) != (y >> 31);
    fl  = {sd, zx || zy, ix || iy, ny, nx};
    exc = (fl != 5'd0);
    err = 1'b0;
    res = 32'h7FC0_0000;
    if (nx || ny)            res = 32'h7FC0_0000;
    else if (ix && iy && sd) err = 1'b1;
    else if (ix)             res = x;
    else if (iy)             res = y;
    else if (zx && zy)       res = (x & y) & 32'h8000_0000;
    else if (zx)             res = y;
    else if (zy)             res = x;
    else                     err = 1'b1;
  endfunction

  function automatic logic [31:0] rand_op(input logic s);
    int c;
    logic [7:0] e;
    logic [22:0] m;
    c = $urandom_range(0, 7);
    m = 23'($urandom);
    case (c)
      0: begin e = 8'hFF; m = m | 23'd1; end
      1: begin e = 8'hFF; m = 23'd0; end
      2: e = 8'h00;
      3: begin e = 8'h00; m = 23'd0; end
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {s, e, m};
  endfunction

  task automatic run_txn(input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] sum_val, input int delay,
                         input bit respond, input int hold);
    logic [4:0]  efl;
    logic        exc, eerr;
    logic [31:0] eres;
    int exp_t, out_t, avail_t, avail_n, w;
    out_t = 0; avail_t = 0; avail_n = 0; w = 0;
    ref_model(xa, xb, efl, exc, eres, eerr);
    if (exc) begin
      exp_t = 2;
    end else if (respond && delay <= TO) begin
      exp_t = 3 + delay;
      if ((sum_val & 32'h7F80_0000) == 32'h7F80_0000) begin
        eres = (sum_val & 32'h8000_0000) | 32'h7F80_0000;
        eerr = 1'b1;
      end else begin
        eres = sum_val;
        eerr = 1'b0;
      end
    end else begin
      exp_t = 3 + TO;
      eres  = 32'h7FC0_0000;
      eerr  = 1'b1;
    end

    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = xa; in_b = xb;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      in_a = $urandom; in_b = $urandom;
      done = 1'b0;
      if (available) begin
        avail_n++;
        avail_t = t;
        check_eq("a_held", a, xa);
        check_eq("b_held", b, xb);
        check_eq("exception_f", exception_f, 0);
      end
      if (out_valid) begin
        out_t = t;
        break;
      end
      check_eq("in_ready_busy", in_ready, 0);
      if (t <= 2) done = 1'($urandom_range(0, 1));
      else if (respond && avail_t > 0 && t == avail_t + delay) begin
        done = 1'b1;
        sum  = sum_val;
      end else sum = $urandom;
    end
    done = 1'b0;
    if (out_t == 0) begin
      check_eq("out_valid_bound", 0, 1);
      in_valid = 1'b0;
      return;
    end
    check_eq("latency", out_t, exp_t);
    check_eq("avail_pulses", avail_n, exc ? 0 : 1);
    if (!exc) check_eq("avail_cycle", avail_t, 2);
    check_eq("out_result", out_result, eres);
    check_eq("out_flags", out_flags, efl);
    check_eq("out_err", out_err, eerr);

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0; in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      done = (h == 0); sum = $urandom;
      @(negedge clk);
      done = 1'b0;
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_result", out_result, eres);
      check_eq("hold_flags", out_flags, efl);
      check_eq("hold_err", out_err, eerr);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("release_valid", out_valid, 0);
    check_eq("release_in_ready", in_ready, 1);
  endtask

  task automatic run_mid_reset();
    int seen;
    seen = 0;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h3F80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_a", a, 0);
    check_eq("rst_b", b, 0);
    check_eq("rst_avail", available, 0);
    check_eq("rst_exc_f", exception_f, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_result", out_result, 0);
    check_eq("rst_out_flags", out_flags, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      done = (i == 3);
      if (out_valid) seen++;
    end
    done = 1'b0;
    check_eq("no_valid_after_reset", seen, 0);
    check_eq("idle_after_reset", in_ready, 1);
  endtask

  initial begin
    logic sa, sb;
    logic [31:0] sv;
    #3;
    check_eq("init_in_ready", in_ready, 1);
    check_eq("init_out_valid", out_valid, 0);
    check_eq("init_out_result", out_result, 0);
    check_eq("init_available", available, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 6, 1'b1, 0);
    run_txn(32'h7FC0_0001, 32'h3F80_0000, 32'h0, 6, 1'b1, 0);
    run_txn(32'h7F80_0000, 32'hFF80_0000, 32'h0, 6, 1'b1, 1);
    run_txn(32'h0000_0000, 32'h4040_0000, 32'h0, 6, 1'b1, 1);
    run_txn(32'h4000_0000, 32'h4040_0000, 32'h0, 6, 1'b0, 2);
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, 1'b1, 5);
    run_txn(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, TO, 1'b1, 0);
    run_txn(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, TO + 1, 1'b1, 1);
    run_txn(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 2, 1'b1, 0);
    run_txn(32'h8000_0000, 32'h8040_0000, 32'h0, 2, 1'b1, 0);
    run_txn(32'h3F80_0000, 32'hBF80_0000, 32'h0, 2, 1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      sa = 1'($urandom);
      sb = ($urandom_range(0, 3) == 0) ? ~sa : sa;
      if ($urandom_range(0, 5) == 0) sv = {1'($urandom), 8'hFF, 23'($urandom)};
      else sv = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
      run_txn(rand_op(sa), rand_op(sb), sv, $urandom_range(1, TO + 2),
              $urandom_range(0, 7) != 0, $urandom_range(0, 3));
    end

    run_mid_reset();
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 6, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_controller.md
FP_ADD_CONTROLLER -- requirements
Module: fp_add_controller

Interface
REQ-001 Parameter: TIMEOUT, default 40, maximum cycles to wait in WAIT for adder done before abort.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; asserted (0) forces every register to its reset value immediately.
REQ-004 in_valid  in  1  operand pair valid.
REQ-005 in_a  in  32  IEEE-754 single operand A.
REQ-006 in_b  in  32  IEEE-754 single operand B.
REQ-007 in_ready  out  1  controller can accept a pair; 1 only in IDLE.
REQ-008 a  out  32  operand A to adder, registered.
REQ-009 b  out  32  operand B to adder, registered.
REQ-010 available  out  1  one-cycle start pulse to adder.
REQ-011 exception_f  out  5  registered classification flags to adder.
REQ-012 sum  in  32  adder result.
REQ-013 done  in  1  adder one-cycle completion pulse.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_result  out  32  final IEEE-754 sum.
REQ-016 out_flags  out  5  classification flags of this transaction.
REQ-017 out_err  out  1  unsupported-operation, overflow or timeout.
REQ-018 out_ready  in  1  consumer accepts result.

Function
REQ-019 States IDLE, CLASS, ISSUE, WAIT, RESP; one transaction in flight.
REQ-020 IDLE: in_ready=1; in_valid=1 -> latch in_a/in_b into a/b, go CLASS.
REQ-021 CLASS (1 cycle): register flags; bit0 A NaN (exp 255, mant!=0); bit1 B NaN; bit2 A or B infinite; bit3 A or B exponent 0 (zero/denormal, denormal flushed to signed zero); bit4 signs differ.
REQ-022 CLASS -> ISSUE if all flags 0; else compute special result, go RESP without touching adder.
REQ-023 Special result priority: NaN -> 32'h7FC00000; inf opposite signs -> 32'h7FC00000 with out_err=1; inf otherwise -> the infinite operand; exactly one operand zero/denormal -> other operand unchanged; both zero/denormal -> {sA&sB, 31'd0}; signs differ only -> 32'h7FC00000 with out_err=1.
REQ-024 ISSUE (1 cycle): available=1, exception_f=flags (all 0), clear timeout counter, go WAIT.
REQ-025 a, b, exception_f SHALL remain constant from CLASS until the WAIT exit.
REQ-026 WAIT: done=1 -> capture sum, go RESP; if sum[30:23]==255 capture {sum[31],8'hFF,23'd0}, out_err=1.
REQ-027 WAIT: counter increments each cycle; at count==TIMEOUT-1 without done -> out_result=32'h7FC00000, out_err=1, go RESP.
REQ-028 done outside WAIT ignored; done and timeout in the same cycle -> done wins.
REQ-029 RESP: out_valid=1, out_result/out_flags/out_err stable; out_ready=1 -> go IDLE next cycle.
REQ-030 Non-exception latency: accept at cycle N, available at N+2, out_valid the cycle after done.
REQ-031 Exception latency: accept at N, out_valid at N+2.
REQ-032 in_valid ignored outside IDLE; back-to-back throughput one transaction per RESP->IDLE cycle.

Reset
REQ-033 reset=0 -> state IDLE, a=b=0, available=0, exception_f=0, out_valid=0, out_result=0, out_flags=0, out_err=0, counter=0; in_ready=1.
REQ-034 Reset asserted mid-transaction abandons it; no out_valid for it after release.

Verification
REQ-035 in_a=32'h3F800000, in_b=32'h3F800000, adder model done 6 cycles after available with sum=32'h40000000 -> out_result=32'h40000000, flags=0, err=0, one available pulse.
REQ-036 in_a=32'h7FC00001, in_b=32'h3F800000 -> out_result=32'h7FC00000, flags bit0, no available pulse, out_valid at N+2.
REQ-037 in_a=32'h7F800000, in_b=32'hFF800000 -> 32'h7FC00000, err=1; in_a=32'h00000000, in_b=32'h40400000 -> 32'h40400000, err=0.
REQ-038 Adder model never asserts done -> out_valid after TIMEOUT cycles in WAIT, 32'h7FC00000, err=1; late done pulse ignored.
REQ-039 Hold out_ready=0 for 5 cycles in RESP with in_valid=1 -> outputs stable, in_ready=0; reset=0 during WAIT -> all outputs at reset values same cycle.
